// File: rtl/decision_tree.sv
// decision_tree: fixed three-node binary decision-tree classifier, one node per clock
// Root splits on X0 < T0; left leaf-parent tests X1 < T1, right tests X2 < T2.
module decision_tree #(
    parameter int                FEAT_W = 8,
    parameter logic [FEAT_W-1:0] X0     = 8'd20,
    parameter logic [FEAT_W-1:0] X1     = 8'd70,
    parameter logic [FEAT_W-1:0] X2     = 8'd30,
    parameter logic [FEAT_W-1:0] T0     = 8'd50,
    parameter logic [FEAT_W-1:0] T1     = 8'd40,
    parameter logic [FEAT_W-1:0] T2     = 8'd60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_i,
    output logic [7:0] y_o,
    output logic       y_valid_o
);
    typedef enum logic [2:0] {IDLE, ROOT, LEFT, RIGHT, DONE} state_t;
    state_t            state, state_nxt;
    logic [FEAT_W-1:0] x0, x1, x2, t0, t1, t2;
    logic [7:0]        y_nxt;
    logic              valid_nxt;
    logic              load;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            y_o       <= 8'h00;
            y_valid_o <= 1'b0;
            x0        <= '0;
            x1        <= '0;
            x2        <= '0;
            t0        <= '0;
            t1        <= '0;
            t2        <= '0;
        end else begin
            state     <= state_nxt;
            y_o       <= y_nxt;
            y_valid_o <= valid_nxt;
            if (load) begin
                x0 <= X0;
                x1 <= X1;
                x2 <= X2;
                t0 <= T0;
                t1 <= T1;
                t2 <= T2;
            end
        end
    end
    // start_i only matters in IDLE/DONE; a restart from DONE clears the held result
    always_comb begin
        state_nxt = state;
        y_nxt     = y_o;
        valid_nxt = y_valid_o;
        load      = 1'b0;
        case (state)
            IDLE: if (start_i) begin
                state_nxt = ROOT;
                load      = 1'b1;
            end
            ROOT: state_nxt = (x0 < t0) ? LEFT : RIGHT;
            LEFT: begin
                state_nxt = DONE;
                y_nxt     = (x1 < t1) ? 8'h01 : 8'h02;
                valid_nxt = 1'b1;
            end
            RIGHT: begin
                state_nxt = DONE;
                y_nxt     = (x2 < t2) ? 8'h03 : 8'h04;
                valid_nxt = 1'b1;
            end
            DONE: if (start_i) begin
                state_nxt = ROOT;
                y_nxt     = 8'h00;
                valid_nxt = 1'b0;
                load      = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_decision_tree.sv
// tb_decision_tree: five parameterisations covering every leaf, scoreboard-checked.
module tb_decision_tree;
    localparam int N = 5;
    localparam logic [7:0] PX0  [N] = '{8'd20, 8'd10, 8'd60, 8'd60, 8'd50};
    localparam logic [7:0] PX1  [N] = '{8'd70, 8'd5,  8'd70, 8'd70, 8'd70};
    localparam logic [7:0] PX2  [N] = '{8'd30, 8'd30, 8'd10, 8'd90, 8'd30};
    localparam logic [7:0] CODE [N] = '{8'h02, 8'h01, 8'h03, 8'h04, 8'h03};

    logic       clk = 0, reset = 0, start_i = 0;
    logic [7:0] y  [N];
    logic       v  [N];
    logic [7:0] py [N];
    logic       pv [N];
    int         checks = 0, errors = 0, cyc = 0;
    int         q [N][$];

    for (genvar g = 0; g < N; g++) begin : g_dut
        decision_tree #(.X0(PX0[g]), .X1(PX1[g]), .X2(PX2[g])) dut (
            .clk       (clk),
            .reset     (reset),
            .start_i   (start_i),
            .y_o       (y[g]),
            .y_valid_o (v[g])
        );
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop an expectation on each valid rise, check hold and zero-when-invalid
    initial for (int i = 0; i < N; i++) begin pv[i] = 0; py[i] = 0; end
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!reset) begin
                q[i].delete();
            end else if (v[i] && !pv[i]) begin
                if (q[i].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid dut%0d: got y=%0h at cycle %0d expected no result", i, y[i], cyc);
                end else begin
                    int e;
                    e = q[i].pop_front();
                    chk($sformatf("latency dut%0d", i), cyc, e >> 8);
                    chk($sformatf("code dut%0d", i), 32'(y[i]), e & 255);
                end
            end else if (v[i]) begin
                chk($sformatf("hold dut%0d", i), 32'(y[i]), 32'(py[i]));
            end
            if (!v[i]) chk($sformatf("zero_when_invalid dut%0d", i), 32'(y[i]), 0);
            pv[i] = v[i];
            py[i] = y[i];
        end
    end

    // Start high for n sampling edges; only the first edge begins a walk
    task automatic issue(input int n);
        @(negedge clk);
        for (int i = 0; i < N; i++) q[i].push_back(((cyc + 3) << 8) | int'(CODE[i]));
        start_i = 1;
        repeat (n) @(negedge clk);
        start_i = 0;
    endtask

    task automatic all_out(input string name, input logic ev, input logic use_code);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s valid dut%0d", name, i), 32'(v[i]), 32'(ev));
            chk($sformatf("%s y dut%0d", name, i), 32'(y[i]), use_code ? 32'(CODE[i]) : 0);
        end
    endtask

    task automatic drained(input string name);
        for (int i = 0; i < N; i++) chk($sformatf("%s pending dut%0d", name, i), q[i].size(), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1 all_out("in_reset", 0, 0);
        reset = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1 all_out("idle_no_start", 0, 0);
        end
        issue(1);
        repeat (15) @(negedge clk);
        #1 all_out("first_result_held", 1, 1);
        drained("first");
        issue(1);
        #1 all_out("restart_clears", 0, 0);
        repeat (6) @(negedge clk);
        #1 all_out("restart_result", 1, 1);
        drained("restart");
        issue(3);
        repeat (10) @(negedge clk);
        #1 all_out("ignored_start_result", 1, 1);
        drained("ignored_start");
        issue(1);
        @(posedge clk);
        #2 reset = 0;
        #1 all_out("reset_mid_walk", 0, 0);
        @(posedge clk);
        #2 reset = 1;
        repeat (8) @(negedge clk);
        #1 all_out("no_result_after_abort", 0, 0);
        issue(1);
        repeat (4) @(negedge clk);
        #1 all_out("post_abort_result", 1, 1);
        drained("post_abort");
        @(posedge clk);
        #2 reset = 0;
        #1 all_out("reset_in_done", 0, 0);
        @(posedge clk);
        #2 reset = 1;
        issue(1);
        repeat (6) @(negedge clk);
        drained("after_reset_done");
        @(negedge clk);
        for (int w = 1; w <= 3; w++)
            for (int i = 0; i < N; i++) q[i].push_back(((cyc + 3 * w) << 8) | int'(CODE[i]));
        start_i = 1;
        repeat (7) @(negedge clk);
        start_i = 0;
        repeat (6) @(negedge clk);
        #1 all_out("continuous_final", 1, 1);
        drained("continuous");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/decision_tree.md
Name: decision_tree

Overview:
- Fixed three-node binary decision-tree classifier, evaluated as a small sequential FSM.
- A one-cycle-or-longer start request triggers one evaluation walk: root node, then one leaf-parent node.
- Produces an 8-bit class code Y1..Y4 and a valid flag.
- Feature values and thresholds are compile-time parameters, so the block sits as a self-contained classification engine behind a start/valid handshake.

Parameters:
- FEAT_W, 8, width of feature values and thresholds (unsigned).
- X0, 8'd20, feature tested at root node.
- X1, 8'd70, feature tested at left node.
- X2, 8'd30, feature tested at right node.
- T0, 8'd50, root threshold.
- T1, 8'd40, left-node threshold.
- T2, 8'd60, right-node threshold.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start_i  input  1  start request, sampled on rising clk.
- y_o  output  8  class code: 8'h01=Y1, 8'h02=Y2, 8'h03=Y3, 8'h04=Y4.
- y_valid_o  output  1  high while y_o holds a completed classification.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, y_o=8'h00, y_valid_o=0, internal feature/threshold registers cleared.
  - Reset mid-walk aborts the evaluation; no result is produced.
  - Classification restarts only on a new start_i after reset release.
- States: IDLE, ROOT, LEFT, RIGHT, DONE (registered, one node per cycle).
- IDLE:
  - start_i=1 at an edge -> ROOT.
  - Load X0..X2 and T0..T2 into working registers.
  - y_valid_o=0.
- ROOT: unsigned compare; X0 < T0 -> LEFT, else -> RIGHT (equality goes right).
- LEFT:
  - X1 < T1 -> y_o=8'h01 (Y1), else y_o=8'h02 (Y2).
  - Next state DONE; y_valid_o=1 registered on the same edge.
- RIGHT:
  - X2 < T2 -> y_o=8'h03 (Y3), else y_o=8'h04 (Y4).
  - Next state DONE; y_valid_o=1.
- Latency: y_valid_o rises on the 3rd rising edge after (and counting) the edge that samples start_i=1.
- DONE:
  - y_o and y_valid_o hold indefinitely.
  - start_i=1 -> ROOT, with y_valid_o cleared to 0 and y_o cleared to 8'h00 on that edge.
- start_i is ignored while in ROOT, LEFT or RIGHT; no queuing.
- start_i held high continuously: a new walk begins each time DONE is reached, giving period 3 cycles. y_valid_o is high for 1 cycle in each period.
- y_o is never any value other than 8'h00..8'h04; 8'h00 only when y_valid_o=0.
- All outputs are registered; no combinational path from start_i to outputs.

Test Plan:
- Reset held low 2 cycles, then released, no start -> y_o=8'h00, y_valid_o=0 indefinitely.
- Default params:
  - Stimulus: start_i high for 1 cycle.
  - Required: after 3 edges, y_valid_o=1, y_o=8'h02 (20<50 left; 70>=40 -> Y2).
  - Values hold for 10+ cycles.
- Param sweep covering all leaves:
  - X0=10,X1=5 -> 8'h01.
  - X0=60,X2=10 -> 8'h03.
  - X0=60,X2=90 -> 8'h04.
  - X0=T0=50 -> right branch.
- Reset asserted in LEFT/RIGHT state (asynchronously, mid-cycle):
  - Outputs go 0 immediately; no valid after release.
  - Next start gives the correct result 3 edges later.
- Second start_i while in DONE -> y_valid_o drops next edge, re-asserts 3 edges after start with same y_o.
- start_i pulsed during ROOT/LEFT -> ignored; exactly one result, latency unchanged.
